blur_row_feeder: RTL

- Producer side of the blur row interface: fetches image rows from pixel memory and drives blur_in, anchor_moving and anchor_x into the blur controller.
- Paces itself on blur_final.
- Walks the frame in vertical strips 16 output pixels wide; within each strip, walks rows top to bottom.
- Sits between the pixel memory read port and the blur stage.

---
 rtl/blur_row_feeder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/blur_row_feeder.sv
// Row feeder for the blur stage: fetches 20-pixel row segments in 16-column strips and
// launches them on blur_final. Define BLUR_ROW_FEEDER_PREFETCH_EN to overlap fetch with blur.
module blur_row_feeder #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned IMG_BASE   = 0,
    parameter int unsigned ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 mem_read,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic [19:0][7:0]     blur_in,
    output logic                 anchor_moving,
    output logic [31:0]          anchor_x,
    input  logic                 blur_final,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned NumStrips = IMG_WIDTH / 16;
    localparam logic [ADDR_BITS-1:0] BaseAddr  = ADDR_BITS'(IMG_BASE);
    localparam logic [ADDR_BITS-1:0] RowStep   = ADDR_BITS'(IMG_WIDTH);
    localparam logic [ADDR_BITS-1:0] StripStep = ADDR_BITS'(16);
    localparam logic [ADDR_BITS-1:0] WordBack  = ADDR_BITS'(4);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StReady,
        StWait,
        StDrain
    } state_e;

    state_e               state_q;
    logic [31:0]          row_q;
    logic [31:0]          strip_q;
    logic [ADDR_BITS-1:0] line_addr_q;   // address of column S*16 in row R
    logic [ADDR_BITS-1:0] strip_addr_q;  // address of column S*16 in row 0
    logic [2:0]           word_q;
    logic [191:0]         shadow_q;
    logic                 shadow_full_q;
    logic [1:0]           guard_q;

    logic                 last_row;
    logic                 last_strip;
    logic                 skip_word;
    logic                 guard_clear;
    logic                 launch;
    logic [ADDR_BITS-1:0] word_addr;
    logic [7:0]           word_bit;

    always_comb begin
        last_row    = (row_q == IMG_HEIGHT - 1);
        last_strip  = (strip_q == NumStrips - 1);
        // Only the outer words of the first and last strip fall outside the image.
        skip_word   = ((word_q == 3'd0) && (strip_q == 32'd0)) ||
                      ((word_q == 3'd5) && last_strip);
        word_addr   = line_addr_q - WordBack + ADDR_BITS'({word_q, 2'b00});
        word_bit    = {word_q, 5'b00000};
        guard_clear = (guard_q == 2'd0);
        launch      = (state_q == StReady) && shadow_full_q && blur_final &&
                      !anchor_moving && guard_clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            row_q         <= '0;
            strip_q       <= '0;
            line_addr_q   <= BaseAddr;
            strip_addr_q  <= BaseAddr;
            word_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            guard_q       <= '0;
            mem_read      <= 1'b0;
            mem_addr      <= '0;
            blur_in       <= '0;
            anchor_moving <= 1'b0;
            anchor_x      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            anchor_moving <= 1'b0;
            frame_done    <= 1'b0;
            if (!guard_clear) begin
                guard_q <= guard_q - 2'd1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy          <= 1'b1;
                        state_q       <= StFetch;
                        row_q         <= '0;
                        strip_q       <= '0;
                        line_addr_q   <= BaseAddr;
                        strip_addr_q  <= BaseAddr;
                        word_q        <= '0;
                        shadow_full_q <= 1'b0;
                    end
                end

                StFetch: begin
                    if (mem_read) begin
                        if (mem_ready) begin
                            shadow_q[word_bit +: 32] <= mem_rdata;
                            mem_read                 <= 1'b0;
                            word_q                   <= word_q + 3'd1;
                        end
                    end else if (word_q == 3'd6) begin
                        shadow_full_q <= 1'b1;
                        state_q       <= StReady;
                    end else if (skip_word) begin
                        shadow_q[word_bit +: 32] <= '0;
                        word_q                   <= word_q + 3'd1;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= word_addr;
                    end
                end

                StReady: begin
                    if (launch) begin
                        blur_in       <= shadow_q[175:16];
                        anchor_x      <= row_q;
                        anchor_moving <= 1'b1;
                        shadow_full_q <= 1'b0;
                        guard_q       <= 2'd2;
                        word_q        <= '0;
                        if (last_row) begin
                            row_q        <= '0;
                            strip_q      <= strip_q + 32'd1;
                            strip_addr_q <= strip_addr_q + StripStep;
                            line_addr_q  <= strip_addr_q + StripStep;
                        end else begin
                            row_q       <= row_q + 32'd1;
                            line_addr_q <= line_addr_q + RowStep;
                        end
                        if (last_row && last_strip) begin
                            state_q <= StDrain;
                        end else begin
`ifdef BLUR_ROW_FEEDER_PREFETCH_EN
                            state_q <= StFetch;
`else
                            state_q <= StWait;
`endif
                        end
                    end
                end

                StWait: begin
                    if (blur_final && guard_clear) begin
                        state_q <= StFetch;
                    end
                end

                StDrain: begin
                    if (blur_final && guard_clear) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
